// File: rtl/unipolar_rz.sv
// Unipolar return-to-zero serial transmitter for WS2812/SK6805-class LED chains, LSB first.
// Latency: line rises on the edge that consumes enable; each phase lasts exactly its N cycles.
// Backpressure: ready (combinational) marks the next edge as a decision point; enable elsewhere is ignored.
module unipolar_rz #(
  parameter int  DATA_WIDTH     = 24,
  parameter real CLOCK_RATE     = 100e6,
  parameter real PERIOD_TIME    = 1.2e-6,
  parameter real ZERO_HIGH_TIME = 0.3e-6,
  parameter real ZERO_LOW_TIME  = 0.8e-6,
  parameter real ONE_HIGH_TIME  = 0.6e-6,
  parameter real ONE_LOW_TIME   = 0.2e-6,
  parameter real RESET_TIME     = 80e-6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  enable,
  output logic                  line,
  output logic                  ready
);

  // Nearest-integer conversion of a duration to clock cycles.
  function automatic int to_cycles(input real t);
    return $rtoi(t * CLOCK_RATE + 0.5);
  endfunction

  localparam int N_ZH = to_cycles(ZERO_HIGH_TIME);
  localparam int N_ZL = to_cycles(ZERO_LOW_TIME);
  localparam int N_OH = to_cycles(ONE_HIGH_TIME);
  localparam int N_OL = to_cycles(ONE_LOW_TIME);
  localparam int N_R  = to_cycles(RESET_TIME);

  localparam int N_MAX_A = (N_ZH > N_ZL) ? N_ZH : N_ZL;
  localparam int N_MAX_B = (N_OH > N_OL) ? N_OH : N_OL;
  localparam int N_MAX_C = (N_MAX_A > N_MAX_B) ? N_MAX_A : N_MAX_B;
  localparam int N_MAX   = (N_MAX_C > N_R) ? N_MAX_C : N_R;

  localparam int CW   = $clog2(N_MAX + 1);
  localparam int LAST = 2 * DATA_WIDTH;
  localparam int SW   = $clog2(LAST + 1);

  localparam logic [SW-1:0] ST_IDLE = '0;
  localparam logic [SW-1:0] ST_LAST = SW'(LAST);

  // Phase loads are N-1 so that a phase ends on the edge where the counter is already 0.
  localparam logic [CW-1:0] ZH_LD = CW'(N_ZH - 1);
  localparam logic [CW-1:0] ZL_LD = CW'(N_ZL - 1);
  localparam logic [CW-1:0] OH_LD = CW'(N_OH - 1);
  localparam logic [CW-1:0] OL_LD = CW'(N_OL - 1);
  localparam logic [CW-1:0] R_LD  = CW'(N_R - 1);

  // Both bit shapes must fit in the nominal bit period.
  if ((ZERO_HIGH_TIME + ZERO_LOW_TIME > PERIOD_TIME) ||
      (ONE_HIGH_TIME + ONE_LOW_TIME > PERIOD_TIME)) begin : g_period_chk
    $fatal(1, "unipolar_rz: HIGH+LOW exceeds PERIOD_TIME");
  end

  // A phase shorter than two cycles cannot be produced by the load-then-count scheme.
  if ((N_ZH < 2) || (N_ZL < 2) || (N_OH < 2) || (N_OL < 2) || (N_R < 2)) begin : g_count_chk
    $fatal(1, "unipolar_rz: a phase rounds to fewer than 2 clock cycles");
  end

  if (DATA_WIDTH < 2) begin : g_width_chk
    $fatal(1, "unipolar_rz: DATA_WIDTH must be at least 2");
  end

  function automatic logic [CW-1:0] high_load(input logic b);
    return b ? OH_LD : ZH_LD;
  endfunction

  function automatic logic [CW-1:0] low_load(input logic b);
    return b ? OL_LD : ZL_LD;
  endfunction

  logic [SW-1:0]         state_q, state_d;
  logic [CW-1:0]         time_counter_q, time_counter_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  line_q, line_d;

  // Next-state logic: count down the current phase, then step odd(high) -> even(low) -> next bit.
  // shift_q[0] is always the bit currently on the wire; it shifts right after each low phase.
  always_comb begin
    state_d        = state_q;
    time_counter_d = time_counter_q;
    shift_d        = shift_q;
    if (time_counter_q != '0) begin
      time_counter_d = time_counter_q - CW'(1);
    end else if (state_q == ST_IDLE) begin
      if (enable) begin
        shift_d        = data;
        state_d        = SW'(1);
        time_counter_d = high_load(data[0]);
      end
    end else if (state_q[0]) begin
      state_d        = state_q + SW'(1);
      time_counter_d = low_load(shift_q[0]);
    end else if (state_q == ST_LAST) begin
      if (enable) begin
        shift_d        = data;
        state_d        = SW'(1);
        time_counter_d = high_load(data[0]);
      end else begin
        state_d        = ST_IDLE;
        time_counter_d = R_LD;
      end
    end else begin
      state_d        = state_q + SW'(1);
      shift_d        = shift_q >> 1;
      time_counter_d = high_load(shift_q[1]);
    end
    line_d = state_d[0];
  end

  // State, counter, word and registered line output; reset aborts any word in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      time_counter_q <= '0;
      shift_q        <= '0;
      line_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      time_counter_q <= time_counter_d;
      shift_q        <= shift_d;
      line_q         <= line_d;
    end
  end

  assign line  = line_q;
  assign ready = !enable &&
                 (((state_q == ST_IDLE) && (time_counter_q == '0)) ||
                  ((state_q == ST_LAST) && (time_counter_q == CW'(1))));

endmodule

// File: tb/tb_unipolar_rz.sv
// Scoreboard bench for unipolar_rz: stimulus pushes expected bits, a line monitor measures pulses.
// Runs the DUT at 10 MHz so the latch interval is 800 cycles and the whole run stays short.
// Expected pulse widths come from the bit times multiplied by the clock rate.
`timescale 1ns/1ps
module tb_unipolar_rz;
  localparam int DW = 24;
  // Cycle counts at 10 MHz: 0.3us, 0.8us, 0.6us, 0.2us, 80us.
  localparam int ZH  = 3;
  localparam int ZL  = 8;
  localparam int OH  = 6;
  localparam int OL  = 2;
  localparam int RST = 800;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable  = 1'b0;
  logic [DW-1:0] data    = '0;
  logic          line;
  logic          ready;

  unipolar_rz #(.DATA_WIDTH(DW), .CLOCK_RATE(10e6)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .data   (data),
    .enable (enable),
    .line   (line),
    .ready  (ready)
  );

  always #50 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_ge(input string name, input longint act, input longint req);
    n_checks++;
    if (act < req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, req);
    end
  endtask

  // Scoreboard: one entry per transmitted bit, in wire order.
  typedef struct {
    logic b;
    logic frame_end;
  } exp_bit_t;
  exp_bit_t exp_q[$];

  task automatic push_word(input logic [DW-1:0] w, input logic frame_end);
    exp_bit_t e;
    for (int i = 0; i < DW; i++) begin
      e.b         = w[i];
      e.frame_end = frame_end && (i == DW - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor state
  logic     prev_line  = 1'b0;
  logic     prev_ready = 1'b0;
  int       hi_len = 0;
  int       lo_len = 0;
  bit       pend_lo = 0;
  bit       pend_last = 0;
  int       pend_lo_req = 0;
  int       bits_in_word = 0;
  longint   last_fall_cyc = 0;
  exp_bit_t mon_e;

  // Measure every high and low run on the line and score it against the queue.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      pend_lo      = 0;
      hi_len       = 0;
      lo_len       = 0;
      bits_in_word = 0;
      prev_line    = 1'b0;
      prev_ready   = 1'b0;
    end else begin
      if (line && !prev_line) begin
        if (pend_lo) begin
          if (pend_last) check_ge("frame_gap", lo_len, pend_lo_req);
          else           check("low_width", lo_len, pend_lo_req);
          pend_lo = 0;
        end
        hi_len = 1;
      end else if (line) begin
        hi_len++;
      end else if (prev_line) begin
        last_fall_cyc = cyc;
        lo_len        = 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got pulse of %0d cycles, expected none", hi_len);
        end else begin
          mon_e = exp_q.pop_front();
          check("high_width", hi_len, mon_e.b ? OH : ZH);
          pend_lo     = 1;
          pend_last   = mon_e.frame_end;
          pend_lo_req = (mon_e.b ? OL : ZL) + (mon_e.frame_end ? RST : 0);
        end
        bits_in_word = (bits_in_word == DW - 1) ? 0 : bits_in_word + 1;
      end else begin
        lo_len++;
      end
      if (ready && !prev_ready)
        check("ready_mid_word", (line || bits_in_word != 0) ? 1 : 0, 0);
      prev_line  = line;
      prev_ready = ready;
    end
  end

  task automatic wait_ready(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got no ready in %0d cycles, expected ready", budget);
    end
  endtask

  // Called right after ready was seen: offer enable for exactly one cycle.
  task automatic issue(input logic [DW-1:0] w);
    @(posedge clock);
    #1;
    enable = 1'b1;
    data   = w;
    @(posedge clock);
    #1;
    enable = 1'b0;
    data   = DW'($urandom);
  endtask

  // Hold enable high with changing data for n cycles; the DUT must not react.
  task automatic hold_enable(input int n);
    enable = 1'b1;
    repeat (n) begin
      @(posedge clock);
      #1;
      data = DW'($urandom);
    end
    enable = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int nwords,
                            input int mid_hold, input int latch_hold);
    bit            ok;
    logic [DW-1:0] w;
    w = base;
    for (int k = 0; k < nwords; k++) begin
      wait_ready((k == 0) ? 2000 : 400, ok);
      if (!ok) return;
      w = base + DW'(k);
      push_word(w, k == nwords - 1);
      issue(w);
      if (k == 0 && mid_hold > 0) hold_enable(mid_hold);
    end
    // Let the final decision point pass without enable so the frame closes.
    wait_ready(400, ok);
    if (!ok) return;
    @(negedge clock);
    @(posedge clock);
    #1;
    if (latch_hold > 0) hold_enable(latch_hold);
    wait_ready(RST + 50, ok);
    if (!ok) return;
    check("latch_cycles", cyc - last_fall_cyc, (w[DW-1] ? OL : ZL) + RST - 1);
    check("idle_state", dut.state_q, 0);
    check("idle_counter", dut.time_counter_q, 0);
  endtask

  initial begin
    bit            ok;
    logic [DW-1:0] w;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_line", line, 0);
    check("reset_ready", ready, 1);
    #10 reset_n = 1'b1;
    #1;
    check("post_reset_ready", ready, 1);
    check("post_reset_line", line, 0);
    check("post_reset_state", dut.state_q, 0);

    // Single word, then back-to-back frame of four incrementing words
    send_frame(24'habcdef, 1, 0, 0);
    send_frame(24'habcdef, 4, 0, 0);

    // Ten frames of four incrementing words
    for (int f = 0; f < 10; f++)
      send_frame((f == 0) ? 24'habcdef : DW'($urandom), 4, 0, 0);

    // Enable and data wiggling mid-word and during the latch interval
    send_frame(DW'($urandom), 1, 150, 400);

    // Reset in the high phase of bit 10
    wait_ready(2000, ok);
    w = DW'($urandom);
    push_word(w, 1'b1);
    issue(w);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      #1;
      if (bits_in_word == 10 && line) ok = 1;
    end
    check("reach_bit10_high", ok, 1);
    #20 reset_n = 1'b0;
    #1;
    check("async_reset_line", line, 0);
    repeat (2) @(negedge clock);
    #10 reset_n = 1'b1;
    #1;
    check("reset_release_ready", ready, 1);
    check("reset_release_line", line, 0);
    send_frame(DW'($urandom), 1, 0, 0);

    repeat (5) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Watchdog in case a wait loop is somehow bypassed.
  initial begin
    #8ms;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
